// File: rtl/fetch_queue.sv
// Fetch stage with an instruction queue feeding decode.
// Owns the PC; a redirect from execute flushes all buffered entries.
module fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger,
  input  logic                         PCSrcE,
  input  logic [ADDR_WIDTH-1:0]        PCTargetE,
  input  logic                         StallD,
  output logic [ADDR_WIDTH-1:0]        IAddr,
  input  logic [DATA_WIDTH-1:0]        IData,
  output logic [DATA_WIDTH-1:0]        InstrD,
  output logic [ADDR_WIDTH-1:0]        PCD,
  output logic [ADDR_WIDTH-1:0]        PCPlus4D,
  output logic                         ValidD,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h13);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pcs_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] pc4_q   [DEPTH];

  logic                  head_valid;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  unused_tgt;

  assign unused_tgt = ^PCTargetE[1:0];
  assign head_valid = (cnt_q != '0);
  assign pc_plus4   = pc_q + FOUR;

  // A pop frees a slot in the same cycle, so a full queue can still push.
  assign pop  = head_valid & ~StallD;
  assign push = trigger & ~PCSrcE & ((cnt_q != FULL) | pop);

  always_comb begin
    pc_d   = pc_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (PCSrcE) begin
      pc_d   = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_plus4;
        wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wptr_q] <= IData;
      pcs_q[wptr_q]   <= pc_q;
      pc4_q[wptr_q]   <= pc_plus4;
    end
  end

  assign IAddr    = pc_q;
  assign ValidD   = head_valid;
  assign Count    = cnt_q;
  assign InstrD   = head_valid ? instr_q[rptr_q] : NOP;
  assign PCD      = head_valid ? pcs_q[rptr_q]   : '0;
  assign PCPlus4D = head_valid ? pc4_q[rptr_q]   : '0;

endmodule
